noc_local_ni: RTL
=================

// Module: noc_local_ni
// PURPOSE
//  Local network interface sitting directly upstream/downstream of a mesh router's LOCAL port.
//  Injection path: buffers core packets, computes routing header (s_delta_x/y), drives router LOCAL input.
//  Ejection path: accepts flits from router LOCAL output, checks destination, buffers them for the core.
//  One instance per mesh node, between the processing element and its router.
// PARAMETERS
//  X_COORD    0   node X coordinate (0..MESH_SIDE-1)
//  Y_COORD    0   node Y coordinate (0..MESH_SIDE-1)
//  TX_DEPTH   4   injection FIFO entries; power of 2, >=2
//  RX_DEPTH   4   ejection FIFO entries; power of 2, >=2
// PORTS  (CW = $clog2(MESH_SIDE); DATA_WIDTH, MESH_SIDE from global_params)
//  clk             in   1    clock
//  rst             in   1    asynchronous active-high reset
//  core_tx_valid   in   1    core offers packet
//  core_tx_ready   out  1    NI can accept packet
//  core_tx_data    in   DW   payload
//  core_tx_dest_x  in   CW   destination X
//  core_tx_dest_y  in   CW   destination Y
//  rtr_in_valid    out  1    flit valid toward router LOCAL input
//  rtr_in_ready    in   1    router LOCAL input ready
//  rtr_in_data     out  DW   payload
//  rtr_in_dest_x   out  CW   destination X
//  rtr_in_dest_y   out  CW   destination Y
//  rtr_in_s_delta_x out 1    1 = dest_x > X_COORD
//  rtr_in_s_delta_y out 1    1 = dest_y > Y_COORD
//  rtr_out_valid   in   1    flit valid from router LOCAL output
//  rtr_out_ready   out  1    NI can accept ejected flit
//  rtr_out_data    in   DW   payload
//  rtr_out_dest_x  in   CW   destination X
//  rtr_out_dest_y  in   CW   destination Y
//  core_rx_valid   out  1    packet available to core
//  core_rx_ready   in   1    core accepts packet
//  core_rx_data    out  DW   payload
//  err_misroute    out  1    sticky: flit with wrong destination was ejected here
//  tx_count        out  16   injected flit count (NI_STATS_EN)
//  rx_count        out  16   delivered flit count (NI_STATS_EN)
// BEHAVIOUR
//  - Transfer on any channel = valid && ready at posedge clk. Sender holds all fields stable while valid && !ready.
//  - Reset: both FIFOs empty; core_tx_ready=1, rtr_out_ready=1, rtr_in_valid=0, core_rx_valid=0;
//    all data/coord/s_delta outputs 0; err_misroute=0; counters 0. Reset mid-transfer discards all buffered flits.
//  - Injection: push {data,dest_x,dest_y,s_delta_x,s_delta_y} on core transfer; s_delta computed at push,
//    unsigned compare against X_COORD/Y_COORD. core_tx_ready = !tx_full (no full-bypass: push refused when full
//    even if pop occurs same cycle). rtr_in_* = FIFO head (show-ahead), rtr_in_valid = !tx_empty; pop on router transfer.
//    Latency core->router: 1 cycle (push edge, head visible next cycle). Self-addressed packets forwarded unchanged.
//  - Ejection: rtr_out_ready = !rx_full. On router transfer, if dest_x==X_COORD && dest_y==Y_COORD push data;
//    otherwise flit is consumed, dropped, err_misroute set to 1 until reset. core_rx_valid = !rx_empty, pop on core transfer.
//  - Simultaneous push+pop on non-full, non-empty FIFO: occupancy unchanged; on empty FIFO: push only (no bypass).
//  - Pointers wrap modulo depth; occupancy counter width $clog2(DEPTH)+1.
// CONFIGURATION
//  - `NOC_NI_STATS_EN defined: tx_count += 1 per router-side injection transfer, rx_count += 1 per core_rx transfer;
//    both saturate at 16'hFFFF.
//  - Undefined: no counter registers; tx_count, rx_count tied to 16'h0000. Ports present in both builds.
// STRUCTURE
//  - global_params: DATA_WIDTH, MESH_SIDE, localparam COORD_W, typedef struct packed flit_t
//    {data, dest_x, dest_y, s_delta_x, s_delta_y}.
//  - Sub-module noc_sync_fifo #(WIDTH, DEPTH): show-ahead FIFO, full/empty flags; instantiated for TX (flit_t) and RX (data).
// TESTING  (MESH_SIDE=4, node X=1,Y=2, depths 4)
//  - Inject data=0xA5, dest=(3,0), rtr_in_ready=1 -> next cycle rtr_in_valid=1, s_delta_x=1, s_delta_y=0, then popped.
//  - rtr_in_ready=0, push 5 packets -> 4 accepted, core_tx_ready=0 on 5th; release ready -> 4 flits out in order.
//  - Eject dest=(1,2) data=0x3C, core_rx_ready=1 -> core_rx_valid=1 with 0x3C one cycle later; err_misroute stays 0.
//  - Eject dest=(0,2) -> flit consumed, no core_rx_valid, err_misroute=1 and held until rst.
//  - core_rx_ready=0, eject 5 valid flits -> rtr_out_ready=0 after 4th; assert rst mid-stream -> all valids 0, readies 1.
//  - With `NOC_NI_STATS_EN: 3 injections, 2 deliveries -> tx_count=3, rx_count=2; without: both 0.

Source files
------------

// File: rtl/noc_local_ni_pkg.sv
// Shared NoC parameters and the injection flit layout.
package noc_local_ni_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned MESH_SIDE  = 4;
  localparam int unsigned COORD_W    = $clog2(MESH_SIDE);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [COORD_W-1:0]    dest_x;
    logic [COORD_W-1:0]    dest_y;
    logic                  s_delta_x;
    logic                  s_delta_y;
  } flit_t;

endpackage

// File: rtl/noc_sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty flags; DEPTH must be a power of 2, >= 2.
module noc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CNTW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // Push is refused whenever full, even if a pop frees a slot in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + CNTW'(1);
    else if (pop_ok && !push_ok) cnt_d = cnt_q - CNTW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) mem_q[wr_q] <= data_i;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/noc_local_ni.sv
// Local network interface between a processing element and its router LOCAL port.
// Optional flit counters enabled by defining NOC_NI_STATS_EN.
module noc_local_ni
  import noc_local_ni_pkg::*;
#(
  parameter int unsigned X_COORD  = 0,
  parameter int unsigned Y_COORD  = 0,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_tx_valid,
  output logic                  core_tx_ready,
  input  logic [DATA_WIDTH-1:0] core_tx_data,
  input  logic [COORD_W-1:0]    core_tx_dest_x,
  input  logic [COORD_W-1:0]    core_tx_dest_y,
  output logic                  rtr_in_valid,
  input  logic                  rtr_in_ready,
  output logic [DATA_WIDTH-1:0] rtr_in_data,
  output logic [COORD_W-1:0]    rtr_in_dest_x,
  output logic [COORD_W-1:0]    rtr_in_dest_y,
  output logic                  rtr_in_s_delta_x,
  output logic                  rtr_in_s_delta_y,
  input  logic                  rtr_out_valid,
  output logic                  rtr_out_ready,
  input  logic [DATA_WIDTH-1:0] rtr_out_data,
  input  logic [COORD_W-1:0]    rtr_out_dest_x,
  input  logic [COORD_W-1:0]    rtr_out_dest_y,
  output logic                  core_rx_valid,
  input  logic                  core_rx_ready,
  output logic [DATA_WIDTH-1:0] core_rx_data,
  output logic                  err_misroute,
  output logic [15:0]           tx_count,
  output logic [15:0]           rx_count
);

  localparam logic [COORD_W-1:0] MY_X = COORD_W'(X_COORD);
  localparam logic [COORD_W-1:0] MY_Y = COORD_W'(Y_COORD);

  flit_t tx_in, tx_head;
  logic  tx_full, tx_empty, rx_full, rx_empty;
  logic  tx_xfer, ej_xfer, ej_local;
  logic  err_q, err_d;

  always_comb begin
    tx_in.data      = core_tx_data;
    tx_in.dest_x    = core_tx_dest_x;
    tx_in.dest_y    = core_tx_dest_y;
    tx_in.s_delta_x = (core_tx_dest_x > MY_X);
    tx_in.s_delta_y = (core_tx_dest_y > MY_Y);
  end

  noc_sync_fifo #(.WIDTH($bits(flit_t)), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .push_i(core_tx_valid), .data_i(tx_in), .full_o(tx_full),
    .pop_i(rtr_in_ready), .data_o(tx_head), .empty_o(tx_empty)
  );

  assign core_tx_ready    = !tx_full;
  assign rtr_in_valid     = !tx_empty;
  assign rtr_in_data      = tx_head.data;
  assign rtr_in_dest_x    = tx_head.dest_x;
  assign rtr_in_dest_y    = tx_head.dest_y;
  assign rtr_in_s_delta_x = tx_head.s_delta_x;
  assign rtr_in_s_delta_y = tx_head.s_delta_y;
  assign tx_xfer          = rtr_in_valid && rtr_in_ready;

  // Misrouted flits are still consumed so the router LOCAL output never stalls on them.
  assign rtr_out_ready = !rx_full;
  assign ej_xfer       = rtr_out_valid && rtr_out_ready;
  assign ej_local      = (rtr_out_dest_x == MY_X) && (rtr_out_dest_y == MY_Y);

  noc_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .push_i(ej_xfer && ej_local), .data_i(rtr_out_data), .full_o(rx_full),
    .pop_i(core_rx_ready), .data_o(core_rx_data), .empty_o(rx_empty)
  );

  assign core_rx_valid = !rx_empty;

  always_comb begin
    err_d = err_q;
    if (ej_xfer && !ej_local) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_misroute = err_q;

`ifdef NOC_NI_STATS_EN
  logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    if (tx_xfer && tx_cnt_q != '1) tx_cnt_d = tx_cnt_q + 16'd1;
    if (core_rx_valid && core_rx_ready && rx_cnt_q != '1) rx_cnt_d = rx_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  assign tx_count = tx_cnt_q;
  assign rx_count = rx_cnt_q;
`else
  assign tx_count = 16'h0000;
  assign rx_count = 16'h0000;
`endif

endmodule
